// File: rtl/regfile_mp_bypass_if.sv
// Register file port bundle: read ports, two write-back ports, issue, flush.
// master = decode/write-back side, slave = register file. Parity ports exist only with REGFILE_PARITY_EN.
interface regfile_mp_bypass_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wb0_en;
  logic [ADDR_W-1:0]        wb0_addr;
  logic [DATA_W-1:0]        wb0_data;
  logic                     wb1_en;
  logic [ADDR_W-1:0]        wb1_addr;
  logic [DATA_W-1:0]        wb1_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;
  logic                     busy_any;
`ifdef REGFILE_PARITY_EN
  logic [NUM_RD-1:0]        rd_perr;
  logic                     inj_perr;

  modport master (
    output rd_addr, wb0_en, wb0_addr, wb0_data,
    output wb1_en, wb1_addr, wb1_data,
    output iss_en, iss_addr, flush, inj_perr,
    input  rd_data, rd_busy, busy_any, rd_perr
  );
  modport slave (
    input  rd_addr, wb0_en, wb0_addr, wb0_data,
    input  wb1_en, wb1_addr, wb1_data,
    input  iss_en, iss_addr, flush, inj_perr,
    output rd_data, rd_busy, busy_any, rd_perr
  );
`else
  modport master (
    output rd_addr, wb0_en, wb0_addr, wb0_data,
    output wb1_en, wb1_addr, wb1_data,
    output iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_any
  );
  modport slave (
    input  rd_addr, wb0_en, wb0_addr, wb0_data,
    input  wb1_en, wb1_addr, wb1_data,
    input  iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_any
  );
`endif
endinterface

// File: rtl/regfile_mp_bypass.sv
// Multi-port register file with write-first bypass and busy scoreboard.
// Ports: clk, reset (async, active-high), bus (slave). Optional parity: `REGFILE_PARITY_EN.
module regfile_mp_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  regfile_mp_bypass_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wb0_ok;
  logic              wb1_ok;
  logic [ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0] rd_busy_c;

  assign wb0_ok = bus.wb0_en && !(ZR && bus.wb0_addr == '0);
  assign wb1_ok = bus.wb1_en && !(ZR && bus.wb1_addr == '0);

`ifdef REGFILE_PARITY_EN
  logic              par_q [DEPTH];
  logic              par_d [DEPTH];
  logic [NUM_RD-1:0] rd_perr_c;
`endif

  always_comb begin
    regs_d = regs_q;
    if (wb0_ok) regs_d[bus.wb0_addr] = bus.wb0_data;
    if (wb1_ok) regs_d[bus.wb1_addr] = bus.wb1_data;
  end

`ifdef REGFILE_PARITY_EN
  // Even parity over data; inj_perr flips it to seed a fault.
  always_comb begin
    par_d = par_q;
    if (wb0_ok)
      par_d[bus.wb0_addr] = ^bus.wb0_data ^ bus.inj_perr;
    if (wb1_ok)
      par_d[bus.wb1_addr] = ^bus.wb1_data ^ bus.inj_perr;
  end
`endif

  // Issue set is applied after write-back clear so a new
  // producer supersedes the one retiring this cycle.
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (bus.wb0_en) busy_d[bus.wb0_addr] = 1'b0;
      if (bus.wb1_en) busy_d[bus.wb1_addr] = 1'b0;
      if (bus.iss_en) busy_d[bus.iss_addr] = 1'b1;
    end
    if (ZR) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
`ifdef REGFILE_PARITY_EN
        par_q[i]  <= 1'b0;
`endif
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
`ifdef REGFILE_PARITY_EN
      par_q  <= par_d;
`endif
      busy_q <= busy_d;
    end
  end

  // Reads are forced to zero while reset is held so no bypass
  // value leaks out of a register file that is being cleared.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    ra        = '0;
`ifdef REGFILE_PARITY_EN
    rd_perr_c = '0;
`endif
    if (!reset) begin
      for (int p = 0; p < NUM_RD; p++) begin
        ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
        rd_busy_c[p] = busy_d[ra];
        if (ZR && ra == '0) begin
          rd_data_c[p*DATA_W +: DATA_W] = '0;
        end else if (bus.wb1_en && bus.wb1_addr == ra) begin
          rd_data_c[p*DATA_W +: DATA_W] = bus.wb1_data;
        end else if (bus.wb0_en && bus.wb0_addr == ra) begin
          rd_data_c[p*DATA_W +: DATA_W] = bus.wb0_data;
        end else begin
          rd_data_c[p*DATA_W +: DATA_W] = regs_q[ra];
`ifdef REGFILE_PARITY_EN
          rd_perr_c[p] = ^regs_q[ra] ^ par_q[ra];
`endif
        end
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.busy_any = |busy_q;
`ifdef REGFILE_PARITY_EN
  assign bus.rd_perr  = rd_perr_c;
`endif
endmodule

// File: doc/regfile_mp_bypass.md
Name: regfile_mp_bypass

Overview:
Parametrised multi-port register file for the next CPU datapath revision.
- NUM_RD combinational read ports and two write-back ports (WB0 from ALU, WB1 from load unit), with write-first bypass.
- A per-register busy scoreboard: set at issue, cleared at write-back, used by the hazard unit.
- Sits between decode (reads, issue) and write-back stages.

Parameters:
DATA_W, 32, data width of each register
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1: register 0 reads as 0, ignores writes, never busy; 0: register 0 is ordinary

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all registers and busy bits
rd_addr  input  NUM_RD*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data, port p at bits [p*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  busy bit of the addressed register, after same-cycle clear/set resolution
wb0_en  input  1  write-back port 0 enable
wb0_addr  input  ADDR_W  write-back port 0 address
wb0_data  input  DATA_W  write-back port 0 data
wb1_en  input  1  write-back port 1 enable
wb1_addr  input  ADDR_W  write-back port 1 address
wb1_data  input  DATA_W  write-back port 1 data
iss_en  input  1  issue: mark destination register busy
iss_addr  input  ADDR_W  issue destination register
flush  input  1  synchronous clear of all busy bits; register contents kept
busy_any  output  1  OR of all busy bits (registered state)

Behaviour:
- Reset (async, active-high): all registers 0, all busy bits 0. During and after reset, rd_data = 0, rd_busy = 0 and busy_any = 0 for every address.
- Storage update on the rising clk edge:
  - wbX_en=1 writes wbX_data to wbX_addr.
  - Both ports to the same address: WB1 wins.
  - ZERO_REG=1 and addr=0: the write is dropped.
- Read path, combinational with zero latency. Priority per port:
  1. ZERO_REG=1 and addr 0 -> 0
  2. wb1_en and wb1_addr match -> wb1_data
  3. wb0_en and wb0_addr match -> wb0_data
  4. otherwise the stored value
- Scoreboard, next state per register r:
  - flush=1: all busy bits 0; iss_en in the same cycle is also ignored.
  - Otherwise, clear if any write-back targets r this cycle; then set if iss_en and iss_addr=r. Set wins over clear on the same register, because the new producer supersedes the old one.
  - ZERO_REG=1: busy[0] is held at 0.
- rd_busy[p] is the next-state busy bit for rd_addr[p], so it reflects this cycle's write-back clear and issue set. Consumers see the hazard cleared in the same cycle the bypass supplies the data.
- busy_any is the OR of the current registered busy bits; it carries no bypass.
- Reset asserted mid-operation overrides any write, issue or flush in that cycle.
- Addresses wrap naturally within ADDR_W; there are no out-of-range entries.

Optional Feature:
REGFILE_PARITY_EN
- Defined:
  - Each entry stores an even-parity bit computed from the write data.
  - Adds output rd_perr (NUM_RD bits): 1 when the stored data plus parity of the addressed entry has odd parity.
  - rd_perr is 0 when the read is bypassed or reads zero-register 0.
  - Adds input inj_perr (1 bit): when high during a write, the stored parity bit is inverted, for verification.
  - Reset clears parity bits to 0, which is consistent with data 0.
- Undefined: no parity storage, and ports rd_perr and inj_perr do not exist.

Test Plan:
- Reset: assert reset mid-run after writing 0xDEADBEEF to r5 -> rd_data for r5 reads 0 immediately (async), busy_any=0.
- Dual-write collision: wb0 writes r7=0x11111111 and wb1 writes r7=0x22222222 in the same cycle -> next cycle r7 reads 0x22222222.
- Bypass: wb0 writes r3=0x0000ABCD while rd_addr[0]=3 in the same cycle -> rd_data[0]=0x0000ABCD before the edge; rd_addr[1]=4 shows the stored r4 value.
- Zero register: ZERO_REG=1, wb1 writes r0=0xFFFFFFFF and iss_addr=0 -> r0 reads 0, rd_busy=0, including during the bypass cycle.
- Scoreboard: issue r9 -> busy_any=1 next cycle. A later cycle with both wb0 to r9 and iss r9 -> r9 stays busy. A wb0 to r9 without issue -> rd_busy=0 in the same cycle and busy_any=0 after the edge.
- Flush and parity: issue r2 and r6, then flush together with iss r8 -> all busy bits 0. With REGFILE_PARITY_EN: write r10 with inj_perr=1 -> later read of r10 gives rd_perr=1; rewrite r10 without inj_perr -> rd_perr=0.
